// File: rtl/peak_pkg.sv
// Shared types and helpers for the peak window detector.
package peak_pkg;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/peak_cmp.sv
// Combinational compare of a sample against an upper and a lower bound.
// gt = a > hi, lt = a < lo; signedness chosen at elaboration.
module peak_cmp #(
  parameter int DATA_W      = 10,
  parameter int SIGNED_MODE = 0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] lo,
  output logic              gt,
  output logic              lt
);

  always_comb begin
    if (SIGNED_MODE != 0) begin
      gt = $signed(a) > $signed(hi);
      lt = $signed(a) < $signed(lo);
    end else begin
      gt = a > hi;
      lt = a < lo;
    end
  end

endmodule

// File: rtl/peak_window_detector.sv
// Running and windowed max/min tracker with first-peak index and LED display.
// All outputs registered: results appear the cycle after the accepting edge.
module peak_window_detector
  import peak_pkg::*;
#(
  parameter int DATA_W      = 10,
  parameter int WIN_LEN     = 16,
  parameter int SIGNED_MODE = 0,
  parameter int LED_W       = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_valid,
  input  logic [DATA_W-1:0]             i_data,
  input  logic                          i_clear,
  output logic [DATA_W-1:0]             o_run_max,
  output logic [DATA_W-1:0]             o_run_min,
  output logic                          o_have_samp,
  output logic [DATA_W-1:0]             o_win_max,
  output logic [DATA_W-1:0]             o_win_min,
  output logic [clog2(WIN_LEN)-1:0]     o_win_idx,
  output logic                          o_win_valid,
  output logic [clog2(WIN_LEN+1)-1:0]   o_win_count,
  output logic [LED_W-1:0]              o_leds
);

  localparam int IDX_W = clog2(WIN_LEN);
  localparam int CNT_W = clog2(WIN_LEN + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   wmax_q, wmax_d, wmin_q, wmin_d;
  logic [IDX_W-1:0]    widx_q, widx_d;
  logic [DATA_W-1:0]   win_max_q, win_max_d, win_min_q, win_min_d;
  logic [IDX_W-1:0]    win_idx_q, win_idx_d;
  logic                win_valid_q, win_valid_d;
  logic [DATA_W-1:0]   run_max_q, run_max_d, run_min_q, run_min_d;
  logic                have_q, have_d;
  logic [LED_W-1:0]    leds_q, leds_d;
  logic [DATA_W-1:0]   led_key;
  logic                win_gt, win_lt, run_gt, run_lt;

  peak_cmp #(.DATA_W(DATA_W), .SIGNED_MODE(SIGNED_MODE)) u_win_cmp (
    .a(i_data), .hi(wmax_q), .lo(wmin_q), .gt(win_gt), .lt(win_lt)
  );

  peak_cmp #(.DATA_W(DATA_W), .SIGNED_MODE(SIGNED_MODE)) u_run_cmp (
    .a(i_data), .hi(run_max_q), .lo(run_min_q), .gt(run_gt), .lt(run_lt)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wmax_d      = wmax_q;
    wmin_d      = wmin_q;
    widx_d      = widx_q;
    win_max_d   = win_max_q;
    win_min_d   = win_min_q;
    win_idx_d   = win_idx_q;
    win_valid_d = 1'b0;
    run_max_d   = run_max_q;
    run_min_d   = run_min_q;
    have_d      = have_q;

    if (i_clear) begin
      // Published window results deliberately survive a soft clear.
      state_d   = S_EMPTY;
      count_d   = '0;
      wmax_d    = '0;
      wmin_d    = '0;
      widx_d    = '0;
      run_max_d = '0;
      run_min_d = '0;
      have_d    = 1'b0;
    end else if (i_valid) begin
      if (!have_q) begin
        run_max_d = i_data;
        run_min_d = i_data;
        have_d    = 1'b1;
      end else begin
        if (run_gt) run_max_d = i_data;
        if (run_lt) run_min_d = i_data;
      end

      if (state_q == S_EMPTY) begin
        wmax_d  = i_data;
        wmin_d  = i_data;
        widx_d  = '0;
        count_d = CNT_W'(1);
        state_d = S_ACCUM;
      end else begin
        // Strict compare so ties keep the earliest index.
        if (win_gt) begin
          wmax_d = i_data;
          widx_d = count_q[IDX_W-1:0];
        end
        if (win_lt) wmin_d = i_data;
        count_d = count_q + CNT_W'(1);
      end

      if (count_d == CNT_W'(WIN_LEN)) begin
        win_max_d   = wmax_d;
        win_min_d   = wmin_d;
        win_idx_d   = widx_d;
        win_valid_d = 1'b1;
        count_d     = '0;
        state_d     = S_EMPTY;
      end
    end

    // Signed mode flips the MSB so the LED bar is monotonic in value.
    led_key = run_max_d;
    if (SIGNED_MODE != 0) led_key[DATA_W-1] = ~run_max_d[DATA_W-1];
    leds_d = have_d ? LED_W'(led_key >> (DATA_W - LED_W)) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_EMPTY;
      count_q     <= '0;
      wmax_q      <= '0;
      wmin_q      <= '0;
      widx_q      <= '0;
      win_max_q   <= '0;
      win_min_q   <= '0;
      win_idx_q   <= '0;
      win_valid_q <= 1'b0;
      run_max_q   <= '0;
      run_min_q   <= '0;
      have_q      <= 1'b0;
      leds_q      <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wmax_q      <= wmax_d;
      wmin_q      <= wmin_d;
      widx_q      <= widx_d;
      win_max_q   <= win_max_d;
      win_min_q   <= win_min_d;
      win_idx_q   <= win_idx_d;
      win_valid_q <= win_valid_d;
      run_max_q   <= run_max_d;
      run_min_q   <= run_min_d;
      have_q      <= have_d;
      leds_q      <= leds_d;
    end
  end

  assign o_run_max   = run_max_q;
  assign o_run_min   = run_min_q;
  assign o_have_samp = have_q;
  assign o_win_max   = win_max_q;
  assign o_win_min   = win_min_q;
  assign o_win_idx   = win_idx_q;
  assign o_win_valid = win_valid_q;
  assign o_win_count = count_q;
  assign o_leds      = leds_q;

endmodule

// File: tb/tb_peak_window_detector.sv
// Directed checks of an unsigned and a signed detector instance, WIN_LEN=4.
// Latency: results sampled 1 time unit after each accepting edge.
// Backpressure: none; stimulus is driven every cycle.
module tb_peak_window_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $error("FAIL timeout: bench did not finish");
        $finish;
    end

    logic       u_reset, u_valid, u_clear;
    logic [9:0] u_data;
    logic [9:0] u_run_max, u_run_min, u_win_max, u_win_min;
    logic       u_have, u_win_valid;
    logic [1:0] u_win_idx;
    logic [2:0] u_count;
    logic [7:0] u_leds;

    peak_window_detector #(.DATA_W(10), .WIN_LEN(4), .SIGNED_MODE(0), .LED_W(8)) u_dut (
        .clk(clk), .reset(u_reset), .i_valid(u_valid), .i_data(u_data), .i_clear(u_clear),
        .o_run_max(u_run_max), .o_run_min(u_run_min), .o_have_samp(u_have),
        .o_win_max(u_win_max), .o_win_min(u_win_min), .o_win_idx(u_win_idx),
        .o_win_valid(u_win_valid), .o_win_count(u_count), .o_leds(u_leds)
    );

    logic       s_reset, s_valid, s_clear;
    logic [9:0] s_data;
    logic [9:0] s_run_max, s_run_min, s_win_max, s_win_min;
    logic       s_have, s_win_valid;
    logic [1:0] s_win_idx;
    logic [2:0] s_count;
    logic [7:0] s_leds;

    peak_window_detector #(.DATA_W(10), .WIN_LEN(4), .SIGNED_MODE(1), .LED_W(8)) s_dut (
        .clk(clk), .reset(s_reset), .i_valid(s_valid), .i_data(s_data), .i_clear(s_clear),
        .o_run_max(s_run_max), .o_run_min(s_run_min), .o_have_samp(s_have),
        .o_win_max(s_win_max), .o_win_min(s_win_min), .o_win_idx(s_win_idx),
        .o_win_valid(s_win_valid), .o_win_count(s_count), .o_leds(s_leds)
    );

    task automatic ustep(input logic v, input logic [9:0] d, input logic c);
        u_valid = v;
        u_data  = d;
        u_clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic sstep(input logic v, input logic [9:0] d);
        s_valid = v;
        s_data  = d;
        s_clear = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        u_reset = 1'b0; u_valid = 1'b0; u_data = '0; u_clear = 1'b0;
        s_reset = 1'b0; s_valid = 1'b0; s_data = '0; s_clear = 1'b0;

        for (int i = 0; i < 3; i++) begin
            ustep(1'b1, 10'd700, 1'b0);
            chk("rst_win_valid", u_win_valid, 1'b0);
        end
        chk("rst_run_max", u_run_max, 10'd0);
        chk("rst_run_min", u_run_min, 10'd0);
        chk("rst_have", u_have, 1'b0);
        chk("rst_win_max", u_win_max, 10'd0);
        chk("rst_win_min", u_win_min, 10'd0);
        chk("rst_win_idx", u_win_idx, 2'd0);
        chk("rst_count", u_count, 3'd0);
        chk("rst_leds", u_leds, 8'd0);

        u_reset = 1'b1;
        ustep(1'b1, 10'd5, 1'b0);
        chk("w1_count1", u_count, 3'd1);
        chk("w1_have", u_have, 1'b1);
        chk("w1_run_max1", u_run_max, 10'd5);
        chk("w1_leds1", u_leds, 8'd1);
        ustep(1'b1, 10'd900, 1'b0);
        chk("w1_count2", u_count, 3'd2);
        ustep(1'b1, 10'd3, 1'b0);
        chk("w1_count3", u_count, 3'd3);
        chk("w1_no_pulse3", u_win_valid, 1'b0);
        ustep(1'b1, 10'd900, 1'b0);
        chk("w1_pulse", u_win_valid, 1'b1);
        chk("w1_max", u_win_max, 10'd900);
        chk("w1_idx", u_win_idx, 2'd1);
        chk("w1_min", u_win_min, 10'd3);
        chk("w1_count0", u_count, 3'd0);
        chk("w1_leds", u_leds, 8'd225);
        chk("w1_run_min", u_run_min, 10'd3);
        ustep(1'b0, 10'd0, 1'b0);
        chk("w1_pulse_end", u_win_valid, 1'b0);
        chk("w1_hold_max", u_win_max, 10'd900);

        ustep(1'b1, 10'd1023, 1'b0);
        ustep(1'b0, 10'd77, 1'b0);
        chk("w2_idle_count", u_count, 3'd1);
        ustep(1'b1, 10'd0, 1'b0);
        ustep(1'b0, 10'd55, 1'b0);
        chk("w2_count2", u_count, 3'd2);
        ustep(1'b1, 10'd1023, 1'b0);
        chk("w2_no_pulse", u_win_valid, 1'b0);
        chk("w2_count3", u_count, 3'd3);
        ustep(1'b1, 10'd0, 1'b0);
        chk("w2_pulse", u_win_valid, 1'b1);
        chk("w2_max", u_win_max, 10'd1023);
        chk("w2_idx_tie", u_win_idx, 2'd0);
        chk("w2_min", u_win_min, 10'd0);
        chk("w2_count0", u_count, 3'd0);
        chk("w2_run_max", u_run_max, 10'd1023);
        chk("w2_run_min", u_run_min, 10'd0);
        chk("w2_leds", u_leds, 8'd255);

        ustep(1'b1, 10'd10, 1'b0);
        ustep(1'b1, 10'd20, 1'b0);
        chk("clr_pre_count", u_count, 3'd2);
        ustep(1'b1, 10'd999, 1'b1);
        chk("clr_count", u_count, 3'd0);
        chk("clr_have", u_have, 1'b0);
        chk("clr_leds", u_leds, 8'd0);
        chk("clr_run_max", u_run_max, 10'd0);
        chk("clr_run_min", u_run_min, 10'd0);
        chk("clr_no_pulse", u_win_valid, 1'b0);
        chk("clr_win_max", u_win_max, 10'd1023);
        chk("clr_win_min", u_win_min, 10'd0);
        chk("clr_win_idx", u_win_idx, 2'd0);
        ustep(1'b1, 10'd7, 1'b0);
        chk("clr_next_count", u_count, 3'd1);
        chk("clr_next_run_max", u_run_max, 10'd7);
        chk("clr_next_run_min", u_run_min, 10'd7);

        ustep(1'b1, 10'd100, 1'b0);
        ustep(1'b1, 10'd200, 1'b0);
        chk("mr_pre_count", u_count, 3'd3);
        u_reset = 1'b0;
        ustep(1'b1, 10'd50, 1'b0);
        chk("mr_count", u_count, 3'd0);
        chk("mr_no_pulse", u_win_valid, 1'b0);
        chk("mr_win_max", u_win_max, 10'd0);
        chk("mr_run_max", u_run_max, 10'd0);
        chk("mr_have", u_have, 1'b0);
        u_reset = 1'b1;
        ustep(1'b1, 10'd40, 1'b0);
        ustep(1'b1, 10'd60, 1'b0);
        ustep(1'b1, 10'd50, 1'b0);
        chk("mr_fresh_no_pulse", u_win_valid, 1'b0);
        chk("mr_fresh_count3", u_count, 3'd3);
        ustep(1'b1, 10'd60, 1'b0);
        chk("mr_fresh_pulse", u_win_valid, 1'b1);
        chk("mr_fresh_max", u_win_max, 10'd60);
        chk("mr_fresh_idx", u_win_idx, 2'd1);
        chk("mr_fresh_min", u_win_min, 10'd40);

        sstep(1'b0, 10'd0);
        s_reset = 1'b1;
        sstep(1'b1, 10'h200);
        chk("sg_leds_first", s_leds, 8'd0);
        chk("sg_have", s_have, 1'b1);
        sstep(1'b1, 10'h1FF);
        sstep(1'b1, 10'h3FF);
        sstep(1'b1, 10'h000);
        chk("sg_pulse", s_win_valid, 1'b1);
        chk("sg_max", s_win_max, 10'h1FF);
        chk("sg_idx", s_win_idx, 2'd1);
        chk("sg_min", s_win_min, 10'h200);
        chk("sg_run_max", s_run_max, 10'h1FF);
        chk("sg_run_min", s_run_min, 10'h200);
        chk("sg_leds", s_leds, 8'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
